// File: rtl/instr_decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, the decode queue and register read.
// The master side drives fetch words and consumes the head; the slave side is the queue.
interface instr_decode_queue_if #(
  parameter int DEPTH     = 4,
  parameter int IMM_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_group;
  logic [3:0]           out_ra;
  logic [3:0]           out_rb;
  logic [3:0]           out_rc;
  logic [3:0]           out_opcode;
  logic [IMM_WIDTH-1:0] out_imm;
  logic [1:0]           out_ldst_type;
  logic                 out_causes_stall;
  logic                 out_bad_group;
  logic [CNT_W-1:0]     count;
  logic                 stall_pending;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_group, out_ra, out_rb, out_rc, out_opcode,
           out_imm, out_ldst_type, out_causes_stall, out_bad_group, count, stall_pending
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_group, out_ra, out_rb, out_rc, out_opcode,
           out_imm, out_ldst_type, out_causes_stall, out_bad_group, count, stall_pending
  );
endinterface

// File: rtl/instr_decode_queue.sv
// Decoded-instruction queue: decodes fetch words on accept, buffers them in a circular
// array and tracks how many queued entries will stall so interrupts can be held off.
module instr_decode_queue #(
  parameter int         DEPTH                = 4,
  parameter int         IMM_WIDTH            = 32,
  parameter logic [3:0] CTRL_FLOW_BAD_OPCODE = 4'hC,
  parameter logic [3:0] IRETA_OPCODE         = 4'h2,
  parameter logic [3:0] IDSTA_OPCODE         = 4'h3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_decode_queue_if.slave   q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]           group;
    logic [3:0]           ra;
    logic [3:0]           rb;
    logic [3:0]           rc;
    logic [3:0]           opcode;
    logic [IMM_WIDTH-1:0] imm;
    logic [1:0]           ldst_type;
    logic                 causes_stall;
    logic                 bad_group;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] instr);
    entry_t e;
    e       = '0;
    e.group = instr[31:28];
    e.ra    = instr[27:24];
    e.rb    = instr[23:20];
    case (instr[31:28])
      4'd0: begin
        e.rc     = instr[19:16];
        e.opcode = instr[3:0];
      end
      4'd1: begin
        e.opcode = instr[19:16];
        e.imm    = IMM_WIDTH'(instr[15:0]);
      end
      4'd2: begin
        e.opcode       = instr[19:16];
        e.imm          = IMM_WIDTH'($signed(instr[15:0]));
        e.causes_stall = (instr[19:16] < CTRL_FLOW_BAD_OPCODE);
      end
      4'd3, 4'd4: begin
        e.rc           = instr[19:16];
        e.opcode       = instr[3:0];
        e.causes_stall = (instr[3:0] < CTRL_FLOW_BAD_OPCODE);
      end
      4'd5: begin
        e.rc           = instr[19:16];
        e.opcode       = instr[15:12];
        e.imm          = IMM_WIDTH'($signed(instr[11:0]));
        e.ldst_type    = instr[13:12];
        e.causes_stall = 1'b1;
      end
      4'd6: begin
        e.rc           = instr[19:16];
        e.opcode       = instr[3:0];
        e.causes_stall = (instr[3:0] == IRETA_OPCODE) || (instr[3:0] == IDSTA_OPCODE);
      end
      default: begin
        // Unknown groups become a NOP so downstream never sees stray register indices.
        e           = '0;
        e.bad_group = 1'b1;
      end
    endcase
    return e;
  endfunction

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] stall_cnt_r;

  entry_t           in_dec_s;
  entry_t           head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             stall_inc_s;
  logic             stall_dec_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] stall_cnt_nxt_s;

  // Handshake qualification and decode of the incoming word.
  always_comb begin
    in_dec_s    = decode(q.in_instr);
    head_s      = mem_r[rd_ptr_r];
    full_s      = (count_r == CNT_W'(DEPTH));
    empty_s     = (count_r == {CNT_W{1'b0}});
    push_s      = q.in_valid & ~full_s;
    pop_s       = q.out_ready & ~empty_s;
    stall_inc_s = push_s & in_dec_s.causes_stall;
    stall_dec_s = pop_s & head_s.causes_stall;
  end

  // Next occupancy and next stall-entry count; a simultaneous up and down cancel.
  always_comb begin
    count_nxt_s     = count_r;
    stall_cnt_nxt_s = stall_cnt_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
    if (stall_inc_s && !stall_dec_s) begin
      stall_cnt_nxt_s = stall_cnt_r + CNT_W'(1);
    end else if (stall_dec_s && !stall_inc_s) begin
      stall_cnt_nxt_s = stall_cnt_r - CNT_W'(1);
    end else begin
      stall_cnt_nxt_s = stall_cnt_r;
    end
  end

  // Pointer, occupancy and stall-count state; flush outranks any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (q.flush) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
    end
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s && !q.flush) begin
      mem_r[wr_ptr_r] <= in_dec_s;
    end
  end

  assign q.in_ready         = ~full_s;
  assign q.out_valid        = ~empty_s;
  assign q.count            = count_r;
  assign q.stall_pending    = (stall_cnt_r != {CNT_W{1'b0}});
  assign q.out_group        = head_s.group;
  assign q.out_ra           = head_s.ra;
  assign q.out_rb           = head_s.rb;
  assign q.out_rc           = head_s.rc;
  assign q.out_opcode       = head_s.opcode;
  assign q.out_imm          = head_s.imm;
  assign q.out_ldst_type    = head_s.ldst_type;
  assign q.out_causes_stall = head_s.causes_stall;
  assign q.out_bad_group    = head_s.bad_group;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: decode vector table, hand-written corner
// sequences and a random run compared against a queue-based reference model.
module tb_instr_decode_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  instr_decode_queue_if #(.DEPTH(DEPTH), .IMM_WIDTH(32)) q ();

  instr_decode_queue #(.DEPTH(DEPTH), .IMM_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  grp;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [1:0]  ldst;
    logic        stall;
    logic        bad;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    dec_t        exp;
  } vec_t;

  dec_t mq[$];
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode taken directly from the encoding rules.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int   g;
    d = '0;
    g = int'(w[31:28]);
    if (g > 6) begin
      d.bad = 1'b1;
      return d;
    end
    d.grp = w[31:28];
    d.ra  = w[27:24];
    d.rb  = w[23:20];
    if (g == 1 || g == 2) begin
      d.op  = w[19:16];
      d.imm = (g == 2 && w[15]) ? (32'hFFFF_0000 | {16'h0000, w[15:0]}) : {16'h0000, w[15:0]};
    end else if (g == 5) begin
      d.rc    = w[19:16];
      d.op    = w[15:12];
      d.imm   = w[11] ? (32'hFFFF_F000 | {20'h00000, w[11:0]}) : {20'h00000, w[11:0]};
      d.ldst  = w[13:12];
      d.stall = 1'b1;
    end else begin
      d.rc = w[19:16];
      d.op = w[3:0];
    end
    if (g >= 2 && g <= 4) d.stall = (d.op < 4'hC);
    if (g == 6) d.stall = (d.op == 4'h2 || d.op == 4'h3);
    return d;
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] grp, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [3:0] rc, input logic [3:0] op,
                              input logic [31:0] imm, input logic [1:0] ldst, input logic stall,
                              input logic bad);
    vec_t v;
    v.instr     = instr;
    v.exp.grp   = grp;
    v.exp.ra    = ra;
    v.exp.rb    = rb;
    v.exp.rc    = rc;
    v.exp.op    = op;
    v.exp.imm   = imm;
    v.exp.ldst  = ldst;
    v.exp.stall = stall;
    v.exp.bad   = bad;
    return v;
  endfunction

  task automatic check_head(input string tag, input dec_t e);
    check({tag, "_group"}, 64'(q.out_group), 64'(e.grp));
    check({tag, "_ra"}, 64'(q.out_ra), 64'(e.ra));
    check({tag, "_rb"}, 64'(q.out_rb), 64'(e.rb));
    check({tag, "_rc"}, 64'(q.out_rc), 64'(e.rc));
    check({tag, "_opcode"}, 64'(q.out_opcode), 64'(e.op));
    check({tag, "_imm"}, 64'(q.out_imm), 64'(e.imm));
    check({tag, "_ldst"}, 64'(q.out_ldst_type), 64'(e.ldst));
    check({tag, "_stall"}, 64'(q.out_causes_stall), 64'(e.stall));
    check({tag, "_bad"}, 64'(q.out_bad_group), 64'(e.bad));
  endtask

  task automatic check_model(input string tag);
    int nst;
    nst = 0;
    foreach (mq[i]) if (mq[i].stall) nst++;
    check({tag, "_in_ready"}, 64'(q.in_ready), 64'(mq.size() != DEPTH));
    check({tag, "_out_valid"}, 64'(q.out_valid), 64'(mq.size() != 0));
    check({tag, "_count"}, 64'(q.count), 64'(mq.size()));
    check({tag, "_stall_pending"}, 64'(q.stall_pending), 64'(nst != 0));
    if (mq.size() != 0) check_head(tag, mq[0]);
  endtask

  // Called at a falling edge: drive, let one rising edge happen, update model, compare.
  task automatic step(input logic v, input logic [31:0] instr, input logic rdy, input logic fl,
                      input string tag);
    logic push;
    logic pop;
    q.in_valid  = v;
    q.in_instr  = instr;
    q.out_ready = rdy;
    q.flush     = fl;
    @(posedge clk);
    push = v && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() != 0);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ref_decode(instr));
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic [31:0] r;
    n_chk = 0;
    n_err = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    q.flush = 1'b0;
    q.in_valid = 1'b0;
    q.in_instr = 32'h0;
    q.out_ready = 1'b0;

    tbl[0]  = mk(32'h0123_0005, 4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 32'h0000_0000, 2'd0, 1'b0, 1'b0);
    tbl[1]  = mk(32'h5120_3FFF, 4'h5, 4'h1, 4'h2, 4'h0, 4'h3, 32'hFFFF_FFFF, 2'd3, 1'b1, 1'b0);
    tbl[2]  = mk(32'h2344_8000, 4'h2, 4'h3, 4'h4, 4'h0, 4'h4, 32'hFFFF_8000, 2'd0, 1'b1, 1'b0);
    tbl[3]  = mk(32'h234C_8000, 4'h2, 4'h3, 4'h4, 4'h0, 4'hC, 32'hFFFF_8000, 2'd0, 1'b0, 1'b0);
    tbl[4]  = mk(32'h9ABC_DEF1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 2'd0, 1'b0, 1'b1);
    tbl[5]  = mk(32'h1567_8ABC, 4'h1, 4'h5, 4'h6, 4'h0, 4'h7, 32'h0000_8ABC, 2'd0, 1'b0, 1'b0);
    tbl[6]  = mk(32'h3789_000B, 4'h3, 4'h7, 4'h8, 4'h9, 4'hB, 32'h0000_0000, 2'd0, 1'b1, 1'b0);
    tbl[7]  = mk(32'h4123_000C, 4'h4, 4'h1, 4'h2, 4'h3, 4'hC, 32'h0000_0000, 2'd0, 1'b0, 1'b0);
    tbl[8]  = mk(32'h6456_0002, 4'h6, 4'h4, 4'h5, 4'h6, 4'h2, 32'h0000_0000, 2'd0, 1'b1, 1'b0);
    tbl[9]  = mk(32'h6456_0004, 4'h6, 4'h4, 4'h5, 4'h6, 4'h4, 32'h0000_0000, 2'd0, 1'b0, 1'b0);
    tbl[10] = mk(32'h5AB4_17FF, 4'h5, 4'hA, 4'hB, 4'h4, 4'h1, 32'h0000_07FF, 2'd1, 1'b1, 1'b0);
    tbl[11] = mk(32'hF000_0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 2'd0, 1'b0, 1'b1);

    #1;
    check("rst_in_ready", 64'(q.in_ready), 64'd1);
    check("rst_out_valid", 64'(q.out_valid), 64'd0);
    check("rst_stall_pending", 64'(q.stall_pending), 64'd0);
    check("rst_count", 64'(q.count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, "idle");

    // Decode table: push into the empty queue, compare against the table, then pop.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].instr, 1'b0, 1'b0, "tbl_push");
      check_head($sformatf("tbl%0d", i), tbl[i].exp);
      check($sformatf("tbl%0d_count", i), 64'(q.count), 64'd1);
      check($sformatf("tbl%0d_pend", i), 64'(q.stall_pending), 64'(tbl[i].exp.stall));
      step(1'b0, 32'h0, 1'b1, 1'b0, "tbl_pop");
      check($sformatf("tbl%0d_pend_after_pop", i), 64'(q.stall_pending), 64'd0);
    end

    // Fill to capacity, then a push attempt while full, then sustained push+pop across wrap.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0100_0000 | 32'(i), 1'b0, 1'b0, "fill");
    check("full_in_ready", 64'(q.in_ready), 64'd0);
    check("full_count", 64'(q.count), 64'd4);
    step(1'b1, 32'h0F00_000F, 1'b0, 1'b0, "full_push_ignored");
    for (int i = 0; i < 8; i++) step(1'b1, 32'h0200_0000 | 32'(i), 1'b1, 1'b0, "wrap");
    check("wrap_count", 64'(q.count), 64'd3);

    // Flush with three entries (two stalling) while also pushing and popping.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
    step(1'b1, 32'h5120_3FFF, 1'b0, 1'b0, "fl_a");
    step(1'b1, 32'h2311_0001, 1'b0, 1'b0, "fl_b");
    step(1'b1, 32'h0123_0005, 1'b0, 1'b0, "fl_c");
    check("preflush_pend", 64'(q.stall_pending), 64'd1);
    step(1'b1, 32'h5000_0000, 1'b1, 1'b1, "flush");
    check("flush_count", 64'(q.count), 64'd0);
    check("flush_out_valid", 64'(q.out_valid), 64'd0);
    check("flush_pend", 64'(q.stall_pending), 64'd0);

    // Asynchronous reset mid-stream, observed before any clock edge.
    step(1'b1, 32'h5120_3FFF, 1'b0, 1'b0, "rs_a");
    step(1'b1, 32'h3789_000B, 1'b0, 1'b0, "rs_b");
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check("arst_count", 64'(q.count), 64'd0);
    check("arst_out_valid", 64'(q.out_valid), 64'd0);
    check("arst_in_ready", 64'(q.in_ready), 64'd1);
    check("arst_pend", 64'(q.stall_pending), 64'd0);
    q.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, "post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      r[31:28] = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
